// File: rtl/flex_stp_pkg.sv
// Shared constants for the flex_stp_deser serial-to-parallel deserialiser.
// Covers idle line level, default word width and bit-stuffing run length.
package flex_stp_pkg;

   localparam int DEFAULT_SIZE = 8;

   // A receive line idles high, so flushed registers read back as all ones.
   localparam logic IDLE_BIT = 1'b1;

   // After this many consecutive accepted ones the transmitter inserts a stuff bit.
   localparam int STUFF_RUN_LEN = 6;
   localparam int RUN_W         = $clog2(STUFF_RUN_LEN + 1);

   typedef logic [RUN_W-1:0] run_cnt_t;

endpackage

// File: rtl/flex_counter.sv
// Counter 0..rollover_val, wraps to 0; rollover_flag is registered and high while count_out == rollover_val.
// Single-cycle update per enabled edge; no backpressure, clear has priority over count_enable.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] next_count;

   always_comb begin
      next_count = count_out;
      if (clear) begin
         next_count = '0;
      end else if (count_enable) begin
         if (count_out == rollover_val) begin
            next_count = '0;
         end else begin
            next_count = count_out + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out     <= '0;
         rollover_flag <= 1'b0;
      end else begin
         count_out     <= next_count;
         rollover_flag <= (next_count == rollover_val);
      end
   end

endmodule

// File: rtl/flex_stp_deser.sv
// Serial-to-parallel deserialiser: word framing by bit counter, valid/ack holding register, sticky overrun.
// Zero added latency (word visible after the SIZE-th bit edge); no backpressure, unacked words are overwritten. Optional unstuffing under FLEX_STP_UNSTUFF_EN.
module flex_stp_deser
   import flex_stp_pkg::*;
#(
   parameter int SIZE  = DEFAULT_SIZE,
   parameter bit MSB   = 1'b1,
   localparam int CNT_W = ($clog2(SIZE) > 1) ? $clog2(SIZE) : 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             shift_enable,
   input  logic             serial_in,
   input  logic             clear,
   input  logic             rd_ack,
   output logic [SIZE-1:0]  parallel_out,
   output logic             word_valid,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_count,
   output logic             stuff_err
);

   localparam logic [SIZE-1:0]  IDLE_WORD = {SIZE{IDLE_BIT}};
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SIZE - 1);

   logic [SIZE-1:0] sr;
   logic [SIZE-1:0] sr_shifted;
   logic            accept;
   logic            last_bit;
   logic            complete;

   always_comb begin
      if (MSB) begin
         sr_shifted = {sr[SIZE-2:0], serial_in};
      end else begin
         sr_shifted = {serial_in, sr[SIZE-1:1]};
      end
   end

`ifdef FLEX_STP_UNSTUFF_EN
   run_cnt_t run_cnt;
   logic     stuff_bit;

   // The bit following a full run of ones is the transmitter's stuff bit, never data.
   assign stuff_bit = (run_cnt == RUN_W'(STUFF_RUN_LEN));
   assign accept    = shift_enable & ~stuff_bit;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         run_cnt   <= '0;
         stuff_err <= 1'b0;
      end else if (clear) begin
         run_cnt   <= '0;
         stuff_err <= 1'b0;
      end else begin
         stuff_err <= 1'b0;
         if (shift_enable) begin
            if (stuff_bit) begin
               run_cnt   <= '0;
               stuff_err <= serial_in;
            end else if (serial_in) begin
               run_cnt <= run_cnt + 1'b1;
            end else begin
               run_cnt <= '0;
            end
         end
      end
   end
`else
   assign accept    = shift_enable;
   assign stuff_err = 1'b0;
`endif

   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .count_enable  (accept),
      .rollover_val  (LAST_BIT),
      .count_out     (bit_count),
      .rollover_flag (last_bit)
   );

   assign complete = accept & last_bit;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr           <= IDLE_WORD;
         parallel_out <= IDLE_WORD;
         word_valid   <= 1'b0;
         overrun      <= 1'b0;
      end else if (clear) begin
         sr           <= IDLE_WORD;
         parallel_out <= IDLE_WORD;
         word_valid   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (accept) begin
            sr <= sr_shifted;
         end
         if (complete) begin
            parallel_out <= sr_shifted;
            word_valid   <= 1'b1;
            // An ack on the completion edge consumes the old word, so no data is lost.
            if (word_valid && !rd_ack) begin
               overrun <= 1'b1;
            end
         end else if (rd_ack) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flex_stp_deser.sv
// Directed self-checking bench for flex_stp_deser (SIZE=8/MSB=1 and SIZE=4/MSB=0 instances).
// Unstuffing scenarios run when FLEX_STP_UNSTUFF_EN is defined.
module tb_flex_stp_deser;

   logic       tb_clk;
   logic       n_rst;

   logic       se8, si8, clr8, ack8;
   logic [7:0] po8;
   logic       vld8, ovr8, serr8;
   logic [2:0] bc8;

   logic       se4, si4, clr4, ack4;
   logic [3:0] po4;
   logic       vld4, ovr4, serr4;
   logic [1:0] bc4;

   int errors = 0;
   int checks = 0;

   flex_stp_deser #(.SIZE(8), .MSB(1'b1)) dut8 (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .shift_enable (se8),
      .serial_in    (si8),
      .clear        (clr8),
      .rd_ack       (ack8),
      .parallel_out (po8),
      .word_valid   (vld8),
      .overrun      (ovr8),
      .bit_count    (bc8),
      .stuff_err    (serr8)
   );

   flex_stp_deser #(.SIZE(4), .MSB(1'b0)) dut4 (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .shift_enable (se4),
      .serial_in    (si4),
      .clear        (clr4),
      .rd_ack       (ack4),
      .parallel_out (po4),
      .word_valid   (vld4),
      .overrun      (ovr4),
      .bit_count    (bc4),
      .stuff_err    (serr4)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives bits w[7] first; with MSB=1 the completed word equals w.
   task automatic shift8(input logic [7:0] w, input logic ack_last);
      for (int i = 7; i >= 0; i--) begin
         se8  = 1'b1;
         si8  = w[i];
         ack8 = (i == 0) ? ack_last : 1'b0;
         @(posedge tb_clk); #1;
      end
      se8  = 1'b0;
      ack8 = 1'b0;
   endtask

   task automatic shift4(input logic [3:0] seq);
      for (int i = 3; i >= 0; i--) begin
         se4 = 1'b1;
         si4 = seq[i];
         @(posedge tb_clk); #1;
      end
      se4 = 1'b0;
   endtask

   task automatic pulse_clear8();
      clr8 = 1'b1;
      @(posedge tb_clk); #1;
      clr8 = 1'b0;
   endtask

   task automatic pulse_ack8();
      ack8 = 1'b1;
      @(posedge tb_clk); #1;
      ack8 = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      #2;
      checks++; if (po8 !== 8'hFF) begin errors++; $display("FAIL reset_po8: got %h want ff", po8); end
      checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL reset_vld8: got %b want 0", vld8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL reset_ovr8: got %b want 0", ovr8); end
      checks++; if (bc8 !== 3'd0) begin errors++; $display("FAIL reset_bc8: got %0d want 0", bc8); end
      checks++; if (serr8 !== 1'b0) begin errors++; $display("FAIL reset_serr8: got %b want 0", serr8); end
      checks++; if (po4 !== 4'hF) begin errors++; $display("FAIL reset_po4: got %h want f", po4); end
      @(posedge tb_clk); #3;
      n_rst = 1'b1;
      @(posedge tb_clk); #1;
   endtask

   task automatic test_msb_word();
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         se8 = 1'b1;
         si8 = w[i];
         @(posedge tb_clk); #1;
         if (i == 1) begin
            checks++; if (bc8 !== 3'd7) begin errors++; $display("FAIL msb_bc7: got %0d want 7", bc8); end
            checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL msb_vld_early: got %b want 0", vld8); end
         end
      end
      se8 = 1'b0;
      checks++; if (po8 !== 8'hA5) begin errors++; $display("FAIL msb_po: got %h want a5", po8); end
      checks++; if (vld8 !== 1'b1) begin errors++; $display("FAIL msb_vld: got %b want 1", vld8); end
      checks++; if (bc8 !== 3'd0) begin errors++; $display("FAIL msb_bc_wrap: got %0d want 0", bc8); end
      pulse_ack8();
      checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL msb_ack_vld: got %b want 0", vld8); end
      checks++; if (po8 !== 8'hA5) begin errors++; $display("FAIL msb_ack_po: got %h want a5", po8); end
   endtask

   task automatic test_lsb_word();
      shift4(4'b1000);   // bits 1,0,0,0
      checks++; if (po4 !== 4'b0001) begin errors++; $display("FAIL lsb_po1: got %b want 0001", po4); end
      checks++; if (vld4 !== 1'b1) begin errors++; $display("FAIL lsb_vld1: got %b want 1", vld4); end
      ack4 = 1'b1;
      @(posedge tb_clk); #1;
      ack4 = 1'b0;
      shift4(4'b0001);   // bits 0,0,0,1
      checks++; if (po4 !== 4'b1000) begin errors++; $display("FAIL lsb_po2: got %b want 1000", po4); end
      checks++; if (ovr4 !== 1'b0) begin errors++; $display("FAIL lsb_ovr: got %b want 0", ovr4); end
   endtask

   task automatic test_back_to_back_overrun();
      pulse_clear8();
      shift8(8'h3C, 1'b0);
      checks++; if (po8 !== 8'h3C) begin errors++; $display("FAIL ovr_first_po: got %h want 3c", po8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b want 0", ovr8); end
      shift8(8'hC3, 1'b0);
      checks++; if (po8 !== 8'hC3) begin errors++; $display("FAIL ovr_second_po: got %h want c3", po8); end
      checks++; if (ovr8 !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr8); end
      pulse_ack8();
      checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL ovr_ack_vld: got %b want 0", vld8); end
      checks++; if (ovr8 !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr8); end
      pulse_clear8();
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL ovr_clear_flag: got %b want 0", ovr8); end
      checks++; if (po8 !== 8'hFF) begin errors++; $display("FAIL ovr_clear_po: got %h want ff", po8); end
   endtask

   task automatic test_ack_on_completion();
      pulse_clear8();
      shift8(8'h5A, 1'b0);
      shift8(8'h96, 1'b1);
      checks++; if (po8 !== 8'h96) begin errors++; $display("FAIL simack_po: got %h want 96", po8); end
      checks++; if (vld8 !== 1'b1) begin errors++; $display("FAIL simack_vld: got %b want 1", vld8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL simack_ovr: got %b want 0", ovr8); end
   endtask

   task automatic test_clear_vs_shift();
      pulse_clear8();
      for (int i = 0; i < 3; i++) begin
         se8 = 1'b1; si8 = 1'b0;
         @(posedge tb_clk); #1;
      end
      checks++; if (bc8 !== 3'd3) begin errors++; $display("FAIL clr_pre_bc: got %0d want 3", bc8); end
      se8 = 1'b1; si8 = 1'b0; clr8 = 1'b1;
      @(posedge tb_clk); #1;
      se8 = 1'b0; clr8 = 1'b0;
      checks++; if (bc8 !== 3'd0) begin errors++; $display("FAIL clr_wins_bc: got %0d want 0", bc8); end
      shift8(8'h81, 1'b0);
      checks++; if (po8 !== 8'h81) begin errors++; $display("FAIL clr_next_po: got %h want 81", po8); end
      checks++; if (vld8 !== 1'b1) begin errors++; $display("FAIL clr_next_vld: got %b want 1", vld8); end
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < 3; i++) begin
         se8 = 1'b1; si8 = 1'b1;
         @(posedge tb_clk); #1;
      end
      se8 = 1'b0;
      n_rst = 1'b0;
      #2;
      checks++; if (bc8 !== 3'd0) begin errors++; $display("FAIL rstmid_bc: got %0d want 0", bc8); end
      checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b want 0", vld8); end
      checks++; if (po8 !== 8'hFF) begin errors++; $display("FAIL rstmid_po: got %h want ff", po8); end
      n_rst = 1'b1;
      @(posedge tb_clk); #1;
      for (int i = 7; i >= 1; i--) begin
         se8 = 1'b1; si8 = i[0];
         @(posedge tb_clk); #1;
      end
      checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL rstmid_7bits_vld: got %b want 0", vld8); end
      si8 = 1'b0;
      @(posedge tb_clk); #1;
      se8 = 1'b0;
      // Bits sent: 1,0,1,0,1,0,1,0
      checks++; if (vld8 !== 1'b1) begin errors++; $display("FAIL rstmid_8bits_vld: got %b want 1", vld8); end
      checks++; if (po8 !== 8'hAA) begin errors++; $display("FAIL rstmid_po_new: got %h want aa", po8); end
   endtask

`ifdef FLEX_STP_UNSTUFF_EN
   task automatic test_unstuff();
      logic [8:0] seq;
      seq = 9'b1111_1101_0;   // 1,1,1,1,1,1,0(stuff),1,0
      pulse_clear8();
      for (int i = 8; i >= 0; i--) begin
         se8 = 1'b1; si8 = seq[i];
         @(posedge tb_clk); #1;
         if (i == 1) begin
            checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL unstuff_vld_early: got %b want 0", vld8); end
         end
         if (i == 2) begin
            checks++; if (bc8 !== 3'd6) begin errors++; $display("FAIL unstuff_bc_hold: got %0d want 6", bc8); end
            checks++; if (serr8 !== 1'b0) begin errors++; $display("FAIL unstuff_zero_silent: got %b want 0", serr8); end
         end
      end
      se8 = 1'b0;
      // Accepted bits 1,1,1,1,1,1,1,0
      checks++; if (po8 !== 8'hFE) begin errors++; $display("FAIL unstuff_po: got %h want fe", po8); end
      checks++; if (vld8 !== 1'b1) begin errors++; $display("FAIL unstuff_vld: got %b want 1", vld8); end
      pulse_clear8();
      for (int i = 0; i < 7; i++) begin
         se8 = 1'b1; si8 = 1'b1;
         @(posedge tb_clk); #1;
      end
      se8 = 1'b0;
      checks++; if (serr8 !== 1'b1) begin errors++; $display("FAIL stufferr_pulse: got %b want 1", serr8); end
      checks++; if (bc8 !== 3'd6) begin errors++; $display("FAIL stufferr_bc: got %0d want 6", bc8); end
      @(posedge tb_clk); #1;
      checks++; if (serr8 !== 1'b0) begin errors++; $display("FAIL stufferr_one_cycle: got %b want 0", serr8); end
   endtask
`else
   task automatic test_no_unstuff();
      pulse_clear8();
      for (int i = 0; i < 7; i++) begin
         se8 = 1'b1; si8 = 1'b1;
         @(posedge tb_clk); #1;
         checks++; if (serr8 !== 1'b0) begin errors++; $display("FAIL nostuff_err: got %b want 0", serr8); end
      end
      se8 = 1'b0;
      checks++; if (bc8 !== 3'd7) begin errors++; $display("FAIL nostuff_bc: got %0d want 7", bc8); end
   endtask
`endif

   initial begin
      se8 = 1'b0; si8 = 1'b0; clr8 = 1'b0; ack8 = 1'b0;
      se4 = 1'b0; si4 = 1'b0; clr4 = 1'b0; ack4 = 1'b0;
      n_rst = 1'b1;
      #1;
      test_reset();
      test_msb_word();
      test_lsb_word();
      test_back_to_back_overrun();
      test_ack_on_completion();
      test_clear_vs_shift();
      test_reset_mid_word();
`ifdef FLEX_STP_UNSTUFF_EN
      test_unstuff();
`else
      test_no_unstuff();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
